// File: rtl/divisor_arbiter_if.sv
// Requester and divider signal bundle for divisor_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the
// requests and hosts the divider.
interface divisor_arbiter_if #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned NREQ = 4
) ();

  // requester side
  logic [NREQ-1:0]      Req;
  logic [NREQ*SIZE-1:0] Num_i;
  logic [NREQ*SIZE-1:0] Den_i;
  logic [NREQ-1:0]      Ack;
  logic [SIZE-1:0]      Coc_o;
  logic [SIZE-1:0]      Res_o;
  logic                 DivZero;
  logic                 Err;
  logic                 Busy;

  // shared divider side
  logic                 Div_Start;
  logic [SIZE-1:0]      Div_Num;
  logic [SIZE-1:0]      Div_Den;
  logic [SIZE-1:0]      Div_Coc;
  logic [SIZE-1:0]      Div_Res;
  logic                 Div_Done;

  modport slave (
    input  Req, Num_i, Den_i, Div_Coc, Div_Res, Div_Done,
    output Ack, Coc_o, Res_o, DivZero, Err, Busy, Div_Start, Div_Num, Div_Den
  );

  modport master (
    output Req, Num_i, Den_i, Div_Coc, Div_Res, Div_Done,
    input  Ack, Coc_o, Res_o, DivZero, Err, Busy, Div_Start, Div_Num, Div_Den
  );

endinterface

// File: rtl/divisor_arbiter.sv
// Round-robin arbiter sharing one Start/Done divider among NREQ requesters.
// Zero denominators are answered locally; a watchdog aborts a divider that
// never reports Done. Every output comes straight from a flop.
module divisor_arbiter #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  divisor_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    REPLY,
    ZREPLY
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [SIZE-1:0] coc_q, coc_d;
  logic [SIZE-1:0] res_q, res_d;
  logic [SIZE-1:0] num_q, num_d;
  logic [SIZE-1:0] den_q, den_d;
  logic            divzero_q, divzero_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;

  logic            found_c;
  logic [PW-1:0]   pick_c;
  int unsigned     idx_c;
  logic [SIZE-1:0] sel_num_c;
  logic [SIZE-1:0] sel_den_c;

  // Round-robin pick: first requester at or after ptr+1, wrapping at NREQ.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr_q;
    idx_c   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx_c = 32'(ptr_q) + i;
      if (idx_c >= NREQ) begin
        idx_c = idx_c - NREQ;
      end
      if (!found_c && bus.Req[idx_c[PW-1:0]]) begin
        found_c = 1'b1;
        pick_c  = idx_c[PW-1:0];
      end
    end
  end

  // Operands of the candidate requester.
  assign sel_num_c = bus.Num_i[32'(pick_c) * SIZE +: SIZE];
  assign sel_den_c = bus.Den_i[32'(pick_c) * SIZE +: SIZE];

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    coc_d     = coc_q;
    res_d     = res_q;
    num_d     = num_q;
    den_d     = den_q;
    divzero_d = 1'b0;
    err_d     = 1'b0;
    start_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          ptr_d = pick_c;
          num_d = sel_num_c;
          den_d = sel_den_c;
          if (sel_den_c == '0) begin
            // Division by zero never reaches the divider.
            state_d   = ZREPLY;
            ack_d     = NREQ'(1) << pick_c;
            coc_d     = '1;
            res_d     = sel_num_c;
            divzero_d = 1'b1;
          end else begin
            state_d = LAUNCH;
            start_d = 1'b1;
          end
        end
      end

      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Done wins over a simultaneous watchdog expiry.
        if (bus.Div_Done) begin
          state_d = REPLY;
          ack_d   = NREQ'(1) << ptr_q;
          coc_d   = bus.Div_Coc;
          res_d   = bus.Div_Res;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = REPLY;
          ack_d   = NREQ'(1) << ptr_q;
          coc_d   = '0;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end

      REPLY, ZREPLY: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; ptr resets so requester 0 wins first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NREQ - 1);
      cnt_q     <= '0;
      ack_q     <= '0;
      coc_q     <= '0;
      res_q     <= '0;
      num_q     <= '0;
      den_q     <= '0;
      divzero_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      coc_q     <= coc_d;
      res_q     <= res_d;
      num_q     <= num_d;
      den_q     <= den_d;
      divzero_q <= divzero_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
    end
  end

  assign bus.Ack       = ack_q;
  assign bus.Coc_o     = coc_q;
  assign bus.Res_o     = res_q;
  assign bus.DivZero   = divzero_q;
  assign bus.Err       = err_q;
  assign bus.Busy      = busy_q;
  assign bus.Div_Start = start_q;
  assign bus.Div_Num   = num_q;
  assign bus.Div_Den   = den_q;

endmodule

// File: tb/tb_divisor_arbiter.sv
// Directed bench for divisor_arbiter with a behavioural fixed-latency divider.
module tb_divisor_arbiter;

  localparam int unsigned SIZE    = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DIV_LAT = 8;

  logic clk;
  logic rst;

  divisor_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

  divisor_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Divider model: Done DIV_LAT cycles after the Start cycle.
  logic        m_run;
  int unsigned m_cnt;
  logic        m_done;
  logic [31:0] m_coc;
  logic [31:0] m_res;
  logic        spur_done;
  logic        withhold;
  int          start_cnt = 0;

  assign bus.Div_Done = m_done | spur_done;
  assign bus.Div_Coc  = m_coc;
  assign bus.Div_Res  = m_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_coc  <= '0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.Div_Start) begin
        m_run <= 1'b1;
        m_cnt <= 1;
        m_coc <= (bus.Div_Den != 0) ? bus.Div_Num / bus.Div_Den : '1;
        m_res <= (bus.Div_Den != 0) ? bus.Div_Num % bus.Div_Den : bus.Div_Num;
      end else if (m_run) begin
        if (m_cnt == DIV_LAT - 1) begin
          m_run  <= 1'b0;
          m_done <= !withhold;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.Div_Start) start_cnt <= start_cnt + 1;
  end

  task automatic set_op(input int k, input logic [31:0] n, input logic [31:0] d);
    bus.Num_i[k*32 +: 32] = n;
    bus.Den_i[k*32 +: 32] = d;
  endtask

  // Counts negedges until Ack is seen; -1 if the bound expires.
  task automatic wait_ack(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.Ack != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.Req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.Ack); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    n_checks++; if (bus.Coc_o !== 32'h0 || bus.Res_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %0h/%0h expected 0/0", bus.Coc_o, bus.Res_o); end
    n_checks++; if (bus.DivZero !== 1'b0 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", bus.DivZero, bus.Err); end
    n_checks++; if (bus.Div_Start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", bus.Div_Start); end
    n_checks++; if (bus.Div_Num !== 32'h0 || bus.Div_Den !== 32'h0) begin n_fail++; $display("FAIL reset_operands: got %0h/%0h expected 0/0", bus.Div_Num, bus.Div_Den); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int cyc;
    @(negedge clk);
    set_op(2, 32'd100, 32'd7);
    bus.Req = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.Div_Start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", bus.Div_Start); end
    n_checks++; if (bus.Div_Num !== 32'd100 || bus.Div_Den !== 32'd7) begin n_fail++; $display("FAIL single_operands: got %0d/%0d expected 100/7", bus.Div_Num, bus.Div_Den); end
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.Busy); end
    @(negedge clk);
    n_checks++; if (bus.Div_Start !== 1'b0) begin n_fail++; $display("FAIL single_start_len: got %b expected 0", bus.Div_Start); end
    wait_ack(40, cyc);
    n_checks++; if (cyc !== int'(DIV_LAT)) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cyc, DIV_LAT); end
    n_checks++; if (bus.Ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b expected 0100", bus.Ack); end
    n_checks++; if (bus.Coc_o !== 32'd14 || bus.Res_o !== 32'd2) begin n_fail++; $display("FAIL single_result: got %0d/%0d expected 14/2", bus.Coc_o, bus.Res_o); end
    n_checks++; if (bus.DivZero !== 1'b0 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL single_flags: got %b%b expected 00", bus.DivZero, bus.Err); end
    bus.Req = '0;
    @(negedge clk);
    n_checks++; if (bus.Ack !== 4'b0000 || bus.Busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got ack %b busy %b expected 0000 0", bus.Ack, bus.Busy); end
    n_checks++; if (bus.Coc_o !== 32'd14) begin n_fail++; $display("FAIL single_hold: got %0d expected 14", bus.Coc_o); end
  endtask

  task automatic test_fairness();
    int          cyc;
    int          order [5];
    logic [31:0] e_coc [4];
    logic [31:0] e_res [4];
    logic [3:0]  e_ack;
    order = '{0, 1, 2, 3, 0};
    e_coc = '{32'd14, 32'd30, 32'd123, 32'd4095};
    e_res = '{32'd2, 32'd10, 32'd45, 32'd15};
    pulse_reset();
    set_op(0, 32'd100, 32'd7);
    set_op(1, 32'd1000, 32'd33);
    set_op(2, 32'd12345, 32'd100);
    set_op(3, 32'h0000FFFF, 32'd16);
    bus.Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(60, cyc);
      e_ack = 4'b0001 << order[n];
      n_checks++; if (cyc !== ((n == 0) ? int'(DIV_LAT + 2) : int'(DIV_LAT + 3))) begin n_fail++; $display("FAIL rr_gap%0d: got %0d expected %0d", n, cyc, (n == 0) ? DIV_LAT + 2 : DIV_LAT + 3); end
      n_checks++; if (bus.Ack !== e_ack) begin n_fail++; $display("FAIL rr_ack%0d: got %b expected %b", n, bus.Ack, e_ack); end
      n_checks++; if (bus.Coc_o !== e_coc[order[n]] || bus.Res_o !== e_res[order[n]]) begin n_fail++; $display("FAIL rr_result%0d: got %0d/%0d expected %0d/%0d", n, bus.Coc_o, bus.Res_o, e_coc[order[n]], e_res[order[n]]); end
    end
    bus.Req = '0;
    @(negedge clk);
  endtask

  task automatic test_divzero();
    int cyc;
    int s0;
    s0 = start_cnt;
    set_op(1, 32'h1234, 32'd0);
    set_op(3, 32'hABCD, 32'd0);
    bus.Req = 4'b1010;
    wait_ack(5, cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
    n_checks++; if (bus.Ack !== 4'b0010) begin n_fail++; $display("FAIL dz_ack: got %b expected 0010", bus.Ack); end
    n_checks++; if (bus.Coc_o !== 32'hFFFFFFFF || bus.Res_o !== 32'h1234) begin n_fail++; $display("FAIL dz_result: got %0h/%0h expected ffffffff/1234", bus.Coc_o, bus.Res_o); end
    n_checks++; if (bus.DivZero !== 1'b1 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL dz_flags: got %b%b expected 10", bus.DivZero, bus.Err); end
    bus.Req = 4'b1000;
    wait_ack(5, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL dz_back_to_back: got %0d expected 2", cyc); end
    n_checks++; if (bus.Ack !== 4'b1000 || bus.Res_o !== 32'hABCD) begin n_fail++; $display("FAIL dz_second: got %b/%0h expected 1000/abcd", bus.Ack, bus.Res_o); end
    bus.Req = '0;
    @(negedge clk);
    n_checks++; if (bus.DivZero !== 1'b0 || bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL dz_clear: got %b/%b expected 0/0000", bus.DivZero, bus.Ack); end
    n_checks++; if (start_cnt !== s0) begin n_fail++; $display("FAIL dz_no_start: got %0d starts expected %0d", start_cnt, s0); end
  endtask

  task automatic test_timeout();
    int cyc;
    withhold = 1'b1;
    set_op(0, 32'd50, 32'd5);
    bus.Req = 4'b0001;
    wait_ack(TIMEOUT + 20, cyc);
    n_checks++; if (cyc !== int'(TIMEOUT + 2)) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", cyc, TIMEOUT + 2); end
    n_checks++; if (bus.Ack !== 4'b0001 || bus.Err !== 1'b1 || bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL to_ack: got %b err %b dz %b expected 0001 1 0", bus.Ack, bus.Err, bus.DivZero); end
    n_checks++; if (bus.Coc_o !== 32'h0 || bus.Res_o !== 32'h0) begin n_fail++; $display("FAIL to_result: got %0h/%0h expected 0/0", bus.Coc_o, bus.Res_o); end
    bus.Req = '0;
    withhold = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b expected 0", bus.Err); end
    set_op(1, 32'd77, 32'd10);
    bus.Req = 4'b0010;
    wait_ack(40, cyc);
    n_checks++; if (cyc !== int'(DIV_LAT + 2) || bus.Ack !== 4'b0010) begin n_fail++; $display("FAIL to_recover_ack: got %0d/%b expected %0d/0010", cyc, bus.Ack, DIV_LAT + 2); end
    n_checks++; if (bus.Coc_o !== 32'd7 || bus.Res_o !== 32'd7 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL to_recover_result: got %0d/%0d err %b expected 7/7 0", bus.Coc_o, bus.Res_o, bus.Err); end
    bus.Req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int acks;
    set_op(2, 32'd100, 32'd7);
    bus.Req = 4'b0100;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_wait: got %b expected 1", bus.Busy); end
    rst = 1'b1;
    bus.Req = '0;
    @(negedge clk);
    n_checks++; if (bus.Busy !== 1'b0 || bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL rm_idle: got busy %b ack %b expected 0 0000", bus.Busy, bus.Ack); end
    n_checks++; if (bus.Coc_o !== 32'h0 || bus.Res_o !== 32'h0 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL rm_outputs: got %0h/%0h err %b expected 0/0 0", bus.Coc_o, bus.Res_o, bus.Err); end
    n_checks++; if (bus.Div_Num !== 32'h0 || bus.Div_Den !== 32'h0 || bus.Div_Start !== 1'b0) begin n_fail++; $display("FAIL rm_div: got %0h/%0h start %b expected 0/0 0", bus.Div_Num, bus.Div_Den, bus.Div_Start); end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.Ack != '0) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rm_no_ack: got %0d acks expected 0", acks); end
    set_op(0, 32'd9, 32'd4);
    bus.Req = 4'b0101;
    wait_ack(40, cyc);
    n_checks++; if (cyc !== int'(DIV_LAT + 2) || bus.Ack !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant: got %0d/%b expected %0d/0001", cyc, bus.Ack, DIV_LAT + 2); end
    n_checks++; if (bus.Coc_o !== 32'd2 || bus.Res_o !== 32'd1) begin n_fail++; $display("FAIL rm_result: got %0d/%0d expected 2/1", bus.Coc_o, bus.Res_o); end
    bus.Req = '0;
    @(negedge clk);
  endtask

  task automatic test_spurious();
    int cyc;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.Busy !== 1'b0 || bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL sp_ignored: got busy %b ack %b expected 0 0000", bus.Busy, bus.Ack); end
    set_op(3, 32'hFFFFFFFF, 32'd1);
    bus.Req = 4'b1000;
    wait_ack(40, cyc);
    n_checks++; if (cyc !== int'(DIV_LAT + 2) || bus.Ack !== 4'b1000) begin n_fail++; $display("FAIL sp_ack: got %0d/%b expected %0d/1000", cyc, bus.Ack, DIV_LAT + 2); end
    n_checks++; if (bus.Coc_o !== 32'hFFFFFFFF || bus.Res_o !== 32'h0) begin n_fail++; $display("FAIL sp_result: got %0h/%0h expected ffffffff/0", bus.Coc_o, bus.Res_o); end
    n_checks++; if (bus.Err !== 1'b0 || bus.DivZero !== 1'b0) begin n_fail++; $display("FAIL sp_flags: got %b%b expected 00", bus.DivZero, bus.Err); end
    bus.Req = '0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    spur_done = 1'b0;
    withhold  = 1'b0;
    bus.Req   = '0;
    bus.Num_i = '0;
    bus.Den_i = '0;
    test_reset();
    test_single();
    test_fairness();
    test_divzero();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
